// File: rtl/arith_chain_inverse_pipelined.sv
// arith_chain_inverse_pipelined: decoder side of the arith chain.
// Recovers x = ((y - K3) + K2) - K1 through a 4-stage stallable pipeline.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   data_in/valid_in      chain result y from upstream
//   ready_in              high when a beat can be taken this cycle
//   data_out/err_out      recovered x (low bits) and out-of-range flag
//   valid_out/ready_out   downstream handshake
//   err_count             saturating count of delivered error beats
module arith_chain_inverse_pipelined #(
  parameter int DATA_WIDTH_IN  = 8,
  parameter int DATA_WIDTH_OUT = 10,
  parameter int K1             = 5,
  parameter int K2             = 3,
  parameter int K3             = 10,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH_OUT-1:0] data_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  output logic [DATA_WIDTH_IN-1:0]  data_out,
  output logic                      err_out,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [ERR_CNT_W-1:0]      err_count
);

  // One extra bit of headroom so intermediates stay signed
  // without wrapping for any legal K.
  localparam int IW = DATA_WIDTH_OUT + 1;

  typedef logic signed [IW-1:0] sdata_t;

  localparam sdata_t K1S  = sdata_t'(K1);
  localparam sdata_t K2S  = sdata_t'(K2);
  localparam sdata_t K3S  = sdata_t'(K3);
  localparam sdata_t MAXV = sdata_t'((1 << DATA_WIDTH_IN) - 1);

  logic                     s0_v_q, s0_v_d;
  sdata_t                   s0_q, s0_d;
  logic                     s1_v_q, s1_v_d;
  sdata_t                   s1_q, s1_d;
  logic                     s2_v_q, s2_v_d;
  sdata_t                   s2_q, s2_d;
  logic                     vout_q, vout_d;
  logic [DATA_WIDTH_IN-1:0] dout_q, dout_d;
  logic                     eout_q, eout_d;
  logic [ERR_CNT_W-1:0]     ecnt_q, ecnt_d;

  logic   adv;
  sdata_t t3;
  logic   t3_err;
  logic   deliver_err;

  // Global stall: everything moves only when the output
  // register is empty or being drained this cycle.
  assign adv = !vout_q || ready_out;

  assign t3     = s2_q - K1S;
  assign t3_err = t3[IW-1] || (t3 > MAXV);

  assign deliver_err = vout_q && ready_out && eout_q;

  always_comb begin
    s0_v_d = s0_v_q;
    s0_d   = s0_q;
    s1_v_d = s1_v_q;
    s1_d   = s1_q;
    s2_v_d = s2_v_q;
    s2_d   = s2_q;
    vout_d = vout_q;
    dout_d = dout_q;
    eout_d = eout_q;
    ecnt_d = ecnt_q;

    if (adv) begin
      s0_v_d = valid_in;
      s0_d   = sdata_t'({1'b0, data_in});
      s1_v_d = s0_v_q;
      s1_d   = s0_q - K3S;
      s2_v_d = s1_v_q;
      s2_d   = s1_q + K2S;
      vout_d = s2_v_q;
      // Bubbles keep the last data/err; only valid_out drops.
      if (s2_v_q) begin
        dout_d = t3[DATA_WIDTH_IN-1:0];
        eout_d = t3_err;
      end
    end

    if (deliver_err && (ecnt_q != '1)) begin
      ecnt_d = ecnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_v_q <= 1'b0;
      s0_q   <= '0;
      s1_v_q <= 1'b0;
      s1_q   <= '0;
      s2_v_q <= 1'b0;
      s2_q   <= '0;
      vout_q <= 1'b0;
      dout_q <= '0;
      eout_q <= 1'b0;
      ecnt_q <= '0;
    end else begin
      s0_v_q <= s0_v_d;
      s0_q   <= s0_d;
      s1_v_q <= s1_v_d;
      s1_q   <= s1_d;
      s2_v_q <= s2_v_d;
      s2_q   <= s2_d;
      vout_q <= vout_d;
      dout_q <= dout_d;
      eout_q <= eout_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign ready_in  = adv;
  assign valid_out = vout_q;
  assign data_out  = dout_q;
  assign err_out   = eout_q;
  assign err_count = ecnt_q;

endmodule

// File: tb/tb_arith_chain_inverse_pipelined.sv
// tb_arith_chain_inverse_pipelined: directed bench with a
// queue-based reference model for the arith chain decoder.
module tb_arith_chain_inverse_pipelined;

  localparam int K1 = 5;
  localparam int K2 = 3;
  localparam int K3 = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       ready_in;
  logic [7:0] data_out;
  logic       err_out;
  logic       valid_out;
  logic       ready_out = 1'b1;
  logic [7:0] err_count;

  logic [9:0] data_in2 = '0;
  logic       valid_in2 = 1'b0;
  logic       ready_in2;
  logic [7:0] data_out2;
  logic       err_out2;
  logic       valid_out2;
  logic       ready_out2 = 1'b1;
  logic [1:0] err_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arith_chain_inverse_pipelined dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .err_out(err_out), .valid_out(valid_out),
    .ready_out(ready_out), .err_count(err_count)
  );

  arith_chain_inverse_pipelined #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .data_in(data_in2), .valid_in(valid_in2), .ready_in(ready_in2),
    .data_out(data_out2), .err_out(err_out2), .valid_out(valid_out2),
    .ready_out(ready_out2), .err_count(err_count2)
  );

  // {err, data}: x = y - K3 + K2 - K1 in plain integer arithmetic.
  function automatic logic [8:0] model(input logic [9:0] y);
    int t;
    t = int'(y) - K3 + K2 - K1;
    return {(t < 0) || (t > 255), t[7:0]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard state
  logic [8:0] expq[$];
  int         exp_cnt = 0;
  int         delivered = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_do;
  logic       prev_eo;
  int         delivered2 = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      expq.delete();
      exp_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      chk("ready_in_rule", int'(ready_in), int'(!(valid_out && !ready_out)));
      chk("err_count", int'(err_count), exp_cnt);
      if (prev_stall) begin
        chk("stall_valid", int'(valid_out), 1);
        chk("stall_data", int'(data_out), int'(prev_do));
        chk("stall_err", int'(err_out), int'(prev_eo));
      end
      if (valid_in && ready_in) expq.push_back(model(data_in));
      if (valid_out && ready_out) begin
        delivered++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0d err %0d expected none",
                   data_out, err_out);
        end else begin
          e = expq.pop_front();
          chk("beat_data", int'(data_out), int'(e[7:0]));
          chk("beat_err", int'(err_out), int'(e[8]));
          if (err_out && exp_cnt < 255) exp_cnt++;
        end
      end
      prev_stall = valid_out && !ready_out;
      prev_do = data_out;
      prev_eo = err_out;
    end
  end

  always @(negedge clk) begin
    if (!reset && valid_out2 && ready_out2) begin
      delivered2++;
      chk("sat_data", int'(data_out2), 244);
      chk("sat_err", int'(err_out2), 1);
    end
  end

  task automatic send(input logic [9:0] y);
    int n;
    n = 0;
    data_in = y;
    valid_in = 1'b1;
    @(negedge clk);
    while (!ready_in && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready_in 0 expected 1");
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    logic [8:0] m;

    // Model pinned against hand-computed values
    m = model(10'd112); chk("pin_112", int'(m), {1'b0, 8'd100});
    m = model(10'd11);  chk("pin_11", int'(m), {1'b1, 8'd255});
    m = model(10'd300); chk("pin_300", int'(m), {1'b1, 8'd32});
    m = model(10'd0);   chk("pin_0", int'(m), {1'b1, 8'd244});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_err_out", int'(err_out), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_ready_in", int'(ready_in), 1);
    @(posedge clk);
    #1;

    // Test 1: single beat latency
    send(10'd112);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_valid", int'(valid_out), 1);
    chk("t1_data", int'(data_out), 100);
    chk("t1_err", int'(err_out), 0);
    @(negedge clk);
    chk("t1_one_cycle", int'(valid_out), 0);

    // Test 2: back-to-back
    @(posedge clk);
    #1;
    send(10'd12);
    send(10'd267);
    send(10'd11);
    send(10'd300);
    @(negedge clk);
    chk("t2_d0", int'({valid_out, err_out, data_out}), {2'b10, 8'd0});
    @(negedge clk);
    chk("t2_d1", int'({valid_out, err_out, data_out}), {2'b10, 8'd255});
    @(negedge clk);
    chk("t2_d2", int'({valid_out, err_out, data_out}), {2'b11, 8'd255});
    @(negedge clk);
    chk("t2_d3", int'({valid_out, err_out, data_out}), {2'b11, 8'd32});
    @(negedge clk);
    chk("t2_err_count", int'(err_count), 2);
    @(posedge clk);
    #1;

    // Test 3: stalls with ready_out pattern 1,0,0
    delivered = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(10'(5 + i * 31));
      end
      begin
        for (int k = 0; k < 45; k++) begin
          ready_out = (k % 3 == 0);
          @(posedge clk);
          #1;
        end
        ready_out = 1'b1;
      end
    join
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("t3_delivered", delivered, 10);

    // Test 4: saturating counter on narrow instance
    for (int i = 0; i < 5; i++) begin
      data_in2 = 10'd0;
      valid_in2 = 1'b1;
      @(posedge clk);
      #1;
    end
    valid_in2 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t4_delivered", delivered2, 5);
    chk("t4_err_count", int'(err_count2), 3);
    @(posedge clk);
    #1;

    // Test 5: reset with beats in flight
    send(10'd50);
    send(10'd60);
    send(10'd70);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_valid_out", int'(valid_out), 0);
    chk("t5_err_count", int'(err_count), 0);
    chk("t5_ready_in", int'(ready_in), 1);
    repeat (6) @(posedge clk);
    #1;
    send(10'd20);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_fresh_valid", int'(valid_out), 1);
    chk("t5_fresh_data", int'(data_out), 8);
    @(posedge clk);
    #1;

    // Test 6: round trip of encoder outputs
    delivered = 0;
    for (int x = 0; x < 256; x++) send(10'(x + K1 - K2 + K3));
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("t6_delivered", delivered, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
